// File: rtl/prog_mem_loader.sv
// prog_mem_loader: unified cpu program/data memory fronted by a big-endian byte-stream loader.
// Define MEM_CLEAR_EN to zero every word after reset before the loader is allowed to run.
module prog_mem_loader #(
    parameter int            AW        = 12,
    parameter int            DW        = 32,
    parameter logic [AW-1:0] LOAD_BASE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    input  logic          mem_write,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] to_mem,
    output logic [DW-1:0] from_mem,
    output logic          cpu_rst,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   word_count
);
    localparam int          DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL  = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_ERR
    } state_t;

    state_t        state_q;
    logic [1:0]    byte_idx_q;
    logic [23:0]   shift_q;
    logic [AW-1:0] ld_addr_q;
    logic [AW:0]   word_count_q;
    logic          cpu_rst_q;
    logic          load_done_q;
    logic          load_err_q;
`ifdef MEM_CLEAR_EN
    logic [AW-1:0] clr_addr_q;
`endif

    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          full;
    logic          mem_we_d;
    logic [AW-1:0] mem_waddr_d;
    logic [DW-1:0] mem_wdata_d;

    assign ld_ready   = (state_q == S_LOAD);
    assign accept     = ld_valid & ld_ready;
    assign full       = (word_count_q == FULL);
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;
    assign from_mem   = mem[mem_addr];

    // Single write port shared by clear, loader and cpu; the state picks the owner.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_addr;
        mem_wdata_d = to_mem;
        unique case (state_q)
`ifdef MEM_CLEAR_EN
            S_CLEAR: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = clr_addr_q;
                mem_wdata_d = '0;
            end
`endif
            S_LOAD: begin
                mem_we_d    = accept & ~full & (byte_idx_q == 2'd3);
                mem_waddr_d = ld_addr_q;
                mem_wdata_d = {shift_q, ld_byte};
            end
            S_RUN: begin
                mem_we_d = mem_write & ~cpu_rst_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[mem_waddr_d] <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef MEM_CLEAR_EN
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
`else
            state_q    <= S_LOAD;
`endif
            byte_idx_q   <= '0;
            shift_q      <= '0;
            ld_addr_q    <= LOAD_BASE;
            word_count_q <= '0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            // Lags S_RUN entry by one cycle so load_done leads the cpu release.
            cpu_rst_q <= (state_q != S_RUN);
            unique case (state_q)
`ifdef MEM_CLEAR_EN
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) begin
                        state_q <= S_LOAD;
                    end
                end
`endif
                S_LOAD: begin
                    if (accept) begin
                        if (full) begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end else if (byte_idx_q == 2'd3) begin
                            byte_idx_q   <= '0;
                            ld_addr_q    <= ld_addr_q + 1'b1;
                            word_count_q <= word_count_q + 1'b1;
                            if (ld_last) begin
                                state_q     <= S_RUN;
                                load_done_q <= 1'b1;
                            end
                        end else begin
                            shift_q    <= {shift_q[15:0], ld_byte};
                            byte_idx_q <= byte_idx_q + 1'b1;
                            if (ld_last) begin
                                state_q    <= S_ERR;
                                load_err_q <= 1'b1;
                                byte_idx_q <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed checks of load, error, reset-restart, overflow and cpu port.
// Expectations for untouched words follow MEM_CLEAR_EN when the bench is built with it.
module tb_prog_mem_loader;
    localparam int AW = 12;
    localparam int DW = 32;
`ifdef MEM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [7:0]    ld_byte = '0;
    logic          ld_last = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] to_mem = '0;
    logic [DW-1:0] from_mem;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] d;

    prog_mem_loader #(.AW(AW), .DW(DW), .LOAD_BASE(12'h000)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_byte(ld_byte), .ld_last(ld_last),
        .mem_write(mem_write), .mem_addr(mem_addr),
        .to_mem(to_mem), .from_mem(from_mem),
        .cpu_rst(cpu_rst), .load_done(load_done),
        .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ld_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_after_rst", 32'(ld_ready), 32'd1);
    endtask

    task automatic push(input logic [7:0] b, input logic last, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        while (!ld_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_rdy", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a,
                      input logic [31:0] exp);
        mem_addr = a;
        #1;
        chk(tag, from_mem, exp);
    endtask

    initial begin
        rst_pulse();
        wait_ready();
        chk("init_cpu_rst", 32'(cpu_rst), 32'd1);

        // Two-word image
        push(8'h01, 1'b0, 0); push(8'h23, 1'b0, 0);
        push(8'h45, 1'b0, 0); push(8'h67, 1'b0, 0);
        push(8'h89, 1'b0, 1); push(8'hAB, 1'b0, 0);
        push(8'hCD, 1'b0, 2); push(8'hEF, 1'b1, 0);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_cpu_rst_hold", 32'(cpu_rst), 32'd1);
        chk("t1_ready_low", 32'(ld_ready), 32'd0);
        chk("t1_wc", 32'(word_count), 32'd2);
        @(posedge clk);
        #1;
        chk("t1_cpu_rst_fall", 32'(cpu_rst), 32'd0);
        rd("t1_mem0", 12'h000, 32'h01234567);
        rd("t1_mem1", 12'h001, 32'h89ABCDEF);

        // Bytes offered in S_RUN are never taken
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = 8'hFF;
        repeat (5) @(negedge clk);
        chk("t3_run_ready", 32'(ld_ready), 32'd0);
        chk("t3_run_wc", 32'(word_count), 32'd2);
        ld_valid = 1'b0;

        // cpu writes in S_RUN, old word visible until the edge
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 12'h0FF; to_mem = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        chk("t4_wr", from_mem, 32'hDEADBEEF);
        @(negedge clk);
        to_mem = 32'hCAFEF00D;
        #1;
        chk("t4_old_before_edge", from_mem, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        chk("t4_wr2", from_mem, 32'hCAFEF00D);

        // cpu write during S_LOAD ignored, then reset mid-word
        rst_pulse();
        wait_ready();
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 12'h0FF; to_mem = 32'h12345678;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        chk("t4_load_wr_ign", from_mem, CLR ? 32'h0 : 32'hCAFEF00D);
        push(8'h11, 1'b0, 0); push(8'h22, 1'b0, 0);
        rst_pulse();
        wait_ready();
        push(8'hAA, 1'b0, 0); push(8'hBB, 1'b0, 1); push(8'hCC, 1'b0, 0);
        @(negedge clk);
        ld_valid = 1'b1; ld_byte = 8'hDD; ld_last = 1'b1; mem_addr = 12'h000;
        #1;
        chk("t5_rd_old", from_mem, CLR ? 32'h0 : 32'h01234567);
        @(posedge clk);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("t5_mem0", from_mem, 32'hAABBCCDD);
        chk("t5_wc", 32'(word_count), 32'd1);
        chk("t5_done", 32'(load_done), 32'd1);
        rd("t5_mem1", 12'h001, CLR ? 32'h0 : 32'h89ABCDEF);

        // Six-byte image with gaps: truncated word
        rst_pulse();
        wait_ready();
        push(8'h10, 1'b0, $urandom_range(0, 3));
        push(8'h20, 1'b0, $urandom_range(0, 3));
        push(8'h30, 1'b0, $urandom_range(0, 3));
        push(8'h40, 1'b0, $urandom_range(0, 3));
        push(8'h50, 1'b0, $urandom_range(0, 3));
        push(8'h60, 1'b1, $urandom_range(0, 3));
        chk("t2_err", 32'(load_err), 32'd1);
        chk("t2_ready", 32'(ld_ready), 32'd0);
        chk("t2_done", 32'(load_done), 32'd0);
        chk("t2_wc", 32'(word_count), 32'd1);
        rd("t2_mem0", 12'h000, 32'h10203040);
        rd("t2_mem1", 12'h001, CLR ? 32'h0 : 32'h89ABCDEF);
        @(negedge clk);
        ld_valid = 1'b1; mem_write = 1'b1; mem_addr = 12'h0FF;
        to_mem = 32'h55555555;
        repeat (3) @(negedge clk);
        ld_valid = 1'b0; mem_write = 1'b0;
        #1;
        chk("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t2_err_wr_ign", from_mem, CLR ? 32'h0 : 32'hCAFEF00D);
        chk("t2_wc_hold", 32'(word_count), 32'd1);

        // Fill every word, then one byte too many
        rst_pulse();
        wait_ready();
        for (int w = 0; w < 4096; w++) begin
            d = {16'hA5A5, 4'h0, w[11:0]};
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                ld_valid = 1'b1;
                ld_byte  = d[31-8*b -: 8];
            end
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("full_wc", 32'(word_count), 32'd4096);
        chk("full_no_err", 32'(load_err), 32'd0);
        chk("full_ready", 32'(ld_ready), 32'd1);
        rd("full_mem_top", 12'hFFF, 32'hA5A50FFF);
        rd("full_mem0", 12'h000, 32'hA5A50000);
        push(8'h77, 1'b0, 0);
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_ready", 32'(ld_ready), 32'd0);
        chk("ovf_wc", 32'(word_count), 32'd4096);
        chk("ovf_done", 32'(load_done), 32'd0);
        rd("ovf_no_wrap", 12'h000, 32'hA5A50000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
